// File: rtl/alu_seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/done handshake.
// Define SIGNED_DIV_EN for two's-complement (truncating) division; default is unsigned only.
module alu_seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] partRem_q;
  logic [WIDTH-1:0] quoShift_q;
  logic [WIDTH-1:0] denom_q;
  logic [WIDTH-1:0] origDvd_q;
  logic             zeroDen_q;
  logic [CW-1:0]    count_q;
  logic             done_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             divZero_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trialDiff;
  logic [WIDTH-1:0] partRem_d;
  logic [WIDTH-1:0] quoShift_d;
  logic [WIDTH-1:0] magDvd;
  logic [WIDTH-1:0] magDvs;
  logic [WIDTH-1:0] quoResult;
  logic [WIDTH-1:0] remResult;

`ifdef SIGNED_DIV_EN
  logic negQuo_q;
  logic negRem_q;

  always_comb begin
    magDvd    = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    magDvs    = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    quoResult = negQuo_q ? (~quoShift_d + 1'b1) : quoShift_d;
    remResult = negRem_q ? (~partRem_d + 1'b1)  : partRem_d;
  end
`else
  always_comb begin
    magDvd    = dividend;
    magDvs    = divisor;
    quoResult = quoShift_d;
    remResult = partRem_d;
  end
`endif

  // One restoring step; the extra top bit keeps the shifted remainder from overflowing.
  always_comb begin
    shifted   = {partRem_q, quoShift_q[WIDTH-1]};
    trialDiff = shifted - {1'b0, denom_q};
    if (!trialDiff[WIDTH]) begin
      partRem_d  = trialDiff[WIDTH-1:0];
      quoShift_d = {quoShift_q[WIDTH-2:0], 1'b1};
    end else begin
      partRem_d  = shifted[WIDTH-1:0];
      quoShift_d = {quoShift_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      partRem_q   <= '0;
      quoShift_q  <= '0;
      denom_q     <= '0;
      origDvd_q   <= '0;
      zeroDen_q   <= 1'b0;
      count_q     <= '0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      divZero_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
      negQuo_q    <= 1'b0;
      negRem_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            origDvd_q  <= dividend;
            quoShift_q <= magDvd;
            denom_q    <= magDvs;
            partRem_q  <= '0;
            count_q    <= '0;
            zeroDen_q  <= (divisor == '0);
`ifdef SIGNED_DIV_EN
            negQuo_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            negRem_q   <= dividend[WIDTH-1];
`endif
            state_q    <= CALC;
          end
        end
        // A zero divisor spends a single CALC cycle so its done lands one cycle after start.
        CALC: begin
          if (zeroDen_q) begin
            quotient_q  <= '1;
            remainder_q <= origDvd_q;
            divZero_q   <= 1'b1;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else begin
            partRem_q  <= partRem_d;
            quoShift_q <= quoShift_d;
            count_q    <= count_q + CW'(1);
            if (count_q == LAST) begin
              quotient_q  <= quoResult;
              remainder_q <= remResult;
              divZero_q   <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = divZero_q;

endmodule

// File: tb/tb_alu_seq_divider.sv
// Scoreboard bench for alu_seq_divider: stimulus pushes expected results, a negedge monitor pops on done.
module tb_alu_seq_divider;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } expect_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  expect_t sb[$];
  int compared   = 0;
  int mismatched = 0;
  int doneCount  = 0;

  alu_seq_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      doneCount++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        expect_t e;
        e = sb.pop_front();
        checkOutput("quotient", int'(quotient), int'(e.q));
        checkOutput("remainder", int'(remainder), int'(e.r));
        checkOutput("div_by_zero", int'(div_by_zero), int'(e.dz));
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] eq, input logic [W-1:0] er,
                               input logic edz, input bit poke);
    int lat;
    bit busyHeld;
    expect_t e;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.q = eq; e.r = er; e.dz = edz;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 16'hDEAD;
    divisor  = 16'h0003;
    checkOutput("busy_after_start", int'(busy), 1);
    lat = 0;
    busyHeld = 1'b1;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      if (poke && k == 4) begin
        dividend = 16'd50;
        divisor  = 16'd5;
        start    = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) lat = k;
      else if (!busy) busyHeld = 1'b0;
    end
    checkOutput("latency", lat, (b == '0) ? 1 : W);
    if (poke) checkOutput("busy_held", int'(busyHeld), 1);
    @(posedge clk);
    #1;
    checkOutput("idle_after_done", int'(busy), 0);
  endtask

  initial begin
    int baseDone;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_quotient", int'(quotient), 0);
    checkOutput("reset_remainder", int'(remainder), 0);
    checkOutput("reset_dz", int'(div_by_zero), 0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0);
    applyStimulus(16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 1'b0);
    applyStimulus(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1'b0);
    applyStimulus(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b1);
    applyStimulus(16'd0, 16'd9, 16'd0, 16'd0, 1'b0, 1'b0);
`ifdef SIGNED_DIV_EN
    applyStimulus(16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0, 1'b0);
    applyStimulus(16'd7, 16'hFFFE, 16'hFFFD, 16'd1, 1'b0, 1'b0);
    applyStimulus(16'hFFF9, 16'd0, 16'hFFFF, 16'hFFF9, 1'b1, 1'b0);
`else
    applyStimulus(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 1'b0);
    applyStimulus(16'd65535, 16'd255, 16'd257, 16'd0, 1'b0, 1'b0);
    applyStimulus(16'd50000, 16'd123, 16'd406, 16'd62, 1'b0, 1'b0);
    applyStimulus(16'h8000, 16'hFFFF, 16'd0, 16'h8000, 1'b0, 1'b0);
`endif

    // Abort 1000/3 mid-flight with reset; no done may follow.
    baseDone = doneCount;
    @(negedge clk);
    dividend = 16'd1000;
    divisor  = 16'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_quotient", int'(quotient), 0);
    checkOutput("abort_remainder", int'(remainder), 0);
    checkOutput("abort_dz", int'(div_by_zero), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("abort_no_done", doneCount - baseDone, 0);

    applyStimulus(16'd9, 16'd4, 16'd2, 16'd1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
